// File: rtl/rename_freelist_ctrl_if.sv
// Bundle of rename/commit/branch signals between the pipeline and the free-list controller.
// Handshakes: alloc_gnt and ckpt_gnt are combinational replies to alloc_req/ckpt_req in the same
// cycle; a transfer happens at the rising edge where both req and gnt are 1. rel_valid, ckpt_free
// and recover are fire-and-forget: they take effect at the next edge and have no acknowledge.
interface rename_freelist_ctrl_if #(
    parameter int TAG_W  = 6,
    parameter int CKPT_W = 2
);
    logic              alloc_req;
    logic              alloc_gnt;
    logic [TAG_W-1:0]  alloc_tag;
    logic              rel_valid;
    logic [TAG_W-1:0]  rel_tag;
    logic              ckpt_req;
    logic              ckpt_gnt;
    logic [CKPT_W-1:0] ckpt_id;
    logic              ckpt_free;
    logic              recover;
    logic [CKPT_W-1:0] recover_id;
    logic [TAG_W:0]    free_count;
    logic              ready;
    logic              err;

    modport master (
        output alloc_req, rel_valid, rel_tag, ckpt_req, ckpt_free, recover, recover_id,
        input  alloc_gnt, alloc_tag, ckpt_gnt, ckpt_id, free_count, ready, err
    );

    modport slave (
        input  alloc_req, rel_valid, rel_tag, ckpt_req, ckpt_free, recover, recover_id,
        output alloc_gnt, alloc_tag, ckpt_gnt, ckpt_id, free_count, ready, err
    );
endinterface

// File: rtl/rename_freelist_ctrl.sv
// Physical-register free list for rename: one alloc and one release per cycle, with
// branch checkpoints of the head pointer for single-cycle mispredict recovery.
module rename_freelist_ctrl #(
    parameter int PHYS_REGS  = 64,
    parameter int ARCH_REGS  = 32,
    parameter int CKPT_DEPTH = 4,
    parameter int TAG_W      = 6
) (
    input logic                  clk,
    input logic                  rst_n,
    rename_freelist_ctrl_if.slave bus
);
    localparam int CKPT_W = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
    localparam int PTR_W  = TAG_W + 1;
    localparam int N_FREE = PHYS_REGS - ARCH_REGS;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q, tail_q, free_count;
    logic [TAG_W-1:0]    mem [PHYS_REGS];
    logic [PTR_W-1:0]    snap_q [CKPT_DEPTH];
    logic [CKPT_DEPTH-1:0] ckpt_valid_q, ckpt_valid_d, squash;
    logic [CKPT_W-1:0]   ckpt_head_q, ckpt_tail_q, rec_off;
    logic                err_q;

    logic run, alloc_gnt, ckpt_gnt, list_full;
    logic rel_ok, rel_err, rec_ok, rec_err, free_ok, free_err;
    logic             wr_en;
    logic [TAG_W-1:0] wr_data;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && tail_q == PTR_W'(N_FREE - 1)) state_d = ST_RUN;
    end

    assign run        = (state_q == ST_RUN);
    assign free_count = tail_q - head_q;
    assign list_full  = (free_count == PTR_W'(N_FREE));

    assign alloc_gnt = bus.alloc_req & run & ~bus.recover & (free_count != '0);
    assign ckpt_gnt  = bus.ckpt_req & run & ~bus.recover & ~ckpt_valid_q[ckpt_tail_q];

    assign rel_ok   = bus.rel_valid & run & ~list_full;
    assign rel_err  = bus.rel_valid & (~run | list_full);
    assign rec_ok   = run & bus.recover & ckpt_valid_q[bus.recover_id];
    assign rec_err  = run & bus.recover & ~ckpt_valid_q[bus.recover_id];
    assign free_ok  = run & ~bus.recover & bus.ckpt_free & ckpt_valid_q[ckpt_head_q];
    assign free_err = run & ~bus.recover & bus.ckpt_free & ~ckpt_valid_q[ckpt_head_q];

    // Squash the recovered checkpoint and everything younger: age is distance from ckpt_head.
    assign rec_off = bus.recover_id - ckpt_head_q;
    always_comb begin
        squash = '0;
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            squash[i] = ((CKPT_W'(i) - ckpt_head_q) >= rec_off);
        end
    end

    always_comb begin
        ckpt_valid_d = ckpt_valid_q;
        if (rec_ok) begin
            ckpt_valid_d = ckpt_valid_q & ~squash;
        end else begin
            if (free_ok)  ckpt_valid_d[ckpt_head_q] = 1'b0;
            if (ckpt_gnt) ckpt_valid_d[ckpt_tail_q] = 1'b1;
        end
    end

    assign wr_en   = (state_q == ST_INIT) | rel_ok;
    assign wr_data = (state_q == ST_INIT) ? (TAG_W'(ARCH_REGS) + tail_q[TAG_W-1:0]) : bus.rel_tag;

    // Storage has no reset; INIT fills every entry before it can be read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[tail_q[TAG_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            head_q       <= '0;
            tail_q       <= '0;
            ckpt_valid_q <= '0;
            ckpt_head_q  <= '0;
            ckpt_tail_q  <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < CKPT_DEPTH; i++) snap_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            ckpt_valid_q <= ckpt_valid_d;
            err_q        <= err_q | rel_err | rec_err | free_err;
            if (wr_en) tail_q <= tail_q + 1'b1;
            if (rec_ok)         head_q <= snap_q[bus.recover_id];
            else if (alloc_gnt) head_q <= head_q + 1'b1;
            if (rec_ok) begin
                ckpt_tail_q <= bus.recover_id;
            end else begin
                if (free_ok) ckpt_head_q <= ckpt_head_q + 1'b1;
                // Snapshot includes this cycle's allocation so the branch keeps its own tag.
                if (ckpt_gnt) begin
                    snap_q[ckpt_tail_q] <= head_q + PTR_W'(alloc_gnt);
                    ckpt_tail_q         <= ckpt_tail_q + 1'b1;
                end
            end
        end
    end

    assign bus.alloc_gnt  = alloc_gnt;
    assign bus.alloc_tag  = mem[head_q[TAG_W-1:0]];
    assign bus.ckpt_gnt   = ckpt_gnt;
    assign bus.ckpt_id    = ckpt_tail_q;
    assign bus.free_count = free_count;
    assign bus.ready      = run;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// Directed bench for rename_freelist_ctrl: vector tables for per-cycle behaviour plus
// hand-written reset, init-latency and error sequences.
module tb_rename_freelist_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rename_freelist_ctrl_if bus ();

    rename_freelist_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       alloc_req;
        logic       rel_valid;
        logic [5:0] rel_tag;
        logic       ckpt_req;
        logic       ckpt_free;
        logic       recover;
        logic [1:0] recover_id;
        logic       exp_gnt;
        logic [5:0] exp_tag;
        logic       exp_ckpt_gnt;
        logic [1:0] exp_ckpt_id;
        logic [6:0] exp_fc;
    } vec_t;

    vec_t       vec_q[$];
    logic [5:0] exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         vidx    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic a, input logic r, input logic [5:0] rt, input logic c,
                         input logic f, input logic rc, input logic [1:0] rid);
        bus.alloc_req  = a;
        bus.rel_valid  = r;
        bus.rel_tag    = rt;
        bus.ckpt_req   = c;
        bus.ckpt_free  = f;
        bus.recover    = rc;
        bus.recover_id = rid;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic add(input logic a, input logic r, input logic [5:0] rt, input logic c,
                       input logic f, input logic rc, input logic [1:0] rid,
                       input logic eg, input logic [5:0] et, input logic ecg,
                       input logic [1:0] eci, input logic [6:0] efc);
        vec_t v;
        v.alloc_req = a;  v.rel_valid = r; v.rel_tag = rt; v.ckpt_req = c;
        v.ckpt_free = f;  v.recover = rc;  v.recover_id = rid;
        v.exp_gnt = eg;   v.exp_tag = et;  v.exp_ckpt_gnt = ecg;
        v.exp_ckpt_id = eci; v.exp_fc = efc;
        vec_q.push_back(v);
    endtask

    // Drive one vector after the falling edge and check combinational replies before the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v.alloc_req, v.rel_valid, v.rel_tag, v.ckpt_req, v.ckpt_free, v.recover, v.recover_id);
        #1;
        if (v.exp_gnt) exp_q.push_back(v.exp_tag);
        check($sformatf("v%0d_free_count", vidx), int'(bus.free_count), int'(v.exp_fc));
        check($sformatf("v%0d_alloc_gnt", vidx), int'(bus.alloc_gnt), int'(v.exp_gnt));
        check($sformatf("v%0d_ckpt_gnt", vidx), int'(bus.ckpt_gnt), int'(v.exp_ckpt_gnt));
        if (v.exp_ckpt_gnt)
            check($sformatf("v%0d_ckpt_id", vidx), int'(bus.ckpt_id), int'(v.exp_ckpt_id));
        if (bus.alloc_gnt) begin
            if (exp_q.size() == 0) check($sformatf("v%0d_unexpected_grant", vidx), 1, 0);
            else check($sformatf("v%0d_alloc_tag", vidx), int'(bus.alloc_tag), int'(exp_q.pop_front()));
        end
        vidx++;
    endtask

    task automatic run_vecs();
        foreach (vec_q[i]) apply(vec_q[i]);
        vec_q.delete();
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic wait_ready(input int exp_cycles);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_latency", n, exp_cycles);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        bus.alloc_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", int'(bus.ready), 0);
        check("rst_free_count", int'(bus.free_count), 0);
        check("rst_alloc_gnt", int'(bus.alloc_gnt), 0);
        check("rst_ckpt_gnt", int'(bus.ckpt_gnt), 0);
        check("rst_err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_alloc_gnt", int'(bus.alloc_gnt), 0);
        bus.alloc_req = 1'b0;
        wait_ready(32);
        check("init_free_count", int'(bus.free_count), 32);

        // Drain the whole list, hit empty, then a release is granted next cycle.
        for (int i = 0; i < 32; i++)
            add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'(32 + i), 1'b0, 2'd0, 7'(32 - i));
        add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd0);
        add(1'b0, 1'b1, 6'd40, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd0);
        add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'd40, 1'b0, 2'd0, 7'd1);
        run_vecs();

        // Simultaneous alloc+release keeps free_count steady; released tag 5 cycles back out.
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b1, 6'(10 + i), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'(i));
        for (int i = 0; i < 10; i++)
            add(1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, (i < 3) ? 6'(10 + i) : 6'd5,
                1'b0, 2'd0, 7'd3);
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'd5, 1'b0, 2'd0, 7'(3 - i));
        run_vecs();

        // Checkpoint with alloc at free_count=30, five more allocs, then recover to id 0.
        for (int i = 0; i < 30; i++)
            add(1'b0, 1'b1, 6'(20 + i), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'(i));
        add(1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 6'd20, 1'b1, 2'd0, 7'd30);
        for (int i = 0; i < 5; i++)
            add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'(21 + i), 1'b0, 2'd0, 7'(29 - i));
        add(1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd24);
        add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'd21, 1'b0, 2'd0, 7'd29);
        run_vecs();

        // Fill all checkpoints, recover to id 1 with a concurrent release, then retire.
        for (int i = 0; i < 4; i++)
            add(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 2'(i), 7'd28);
        add(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd28);
        add(1'b0, 1'b1, 6'd60, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 6'd0, 1'b0, 2'd0, 7'd28);
        add(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b1, 2'd1, 7'd29);
        add(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd29);
        add(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd29);
        run_vecs();
        check("ckpt_ok_err", int'(bus.err), 0);

        // Recover to an invalid checkpoint: err, head unchanged, err stays set.
        add(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 6'd0, 1'b0, 2'd0, 7'd29);
        add(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd29);
        run_vecs();
        check("bad_recover_err", int'(bus.err), 1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", int'(bus.err), 1);

        // Reset pulse 10 cycles into INIT restarts initialisation.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_err", int'(bus.err), 0);
        check("rst2_ready", int'(bus.ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_init_free_count", int'(bus.free_count), 0);
        check("mid_init_ready", int'(bus.ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(32);
        check("reinit_free_count", int'(bus.free_count), 32);

        // Release into a full list is dropped and flagged.
        add(1'b0, 1'b1, 6'd7, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 6'd0, 1'b0, 2'd0, 7'd32);
        add(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 6'd32, 1'b0, 2'd0, 7'd32);
        run_vecs();
        check("full_rel_err", int'(bus.err), 1);

        // Release during INIT is dropped and flagged.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rel_valid = 1'b1;
        bus.rel_tag   = 6'd3;
        @(posedge clk);
        #1;
        idle();
        check("init_rel_err", int'(bus.err), 1);
        wait_ready(31);
        check("init_rel_free_count", int'(bus.free_count), 32);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rename_freelist_ctrl.md
Name: rename_freelist_ctrl

Overview:
- Allocation controller for the physical-register free list used by the out-of-order rename stage.
- Hands one free physical tag per cycle to rename and accepts one released tag per cycle from commit.
- Keeps a small set of branch checkpoints of the allocation pointer. On a mispredict it restores the pointer in one cycle, so speculatively allocated tags become free again.
- Owns the free-list storage and its head/tail pointers. After reset it runs its own initialisation sequence.

Parameters:
- PHYS_REGS, 64: total physical registers; also the free-list storage depth.
- ARCH_REGS, 32: architectural registers, mapped 1:1 to tags 0..ARCH_REGS-1 at reset.
- CKPT_DEPTH, 4: number of branch checkpoints (power of two).
- TAG_W, 6: physical tag width, equal to clog2(PHYS_REGS).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- alloc_req, input, 1: rename requests one tag this cycle.
- alloc_gnt, output, 1: grant; tag is consumed at this edge.
- alloc_tag, output, TAG_W: tag at the head; valid whenever alloc_gnt=1.
- rel_valid, input, 1: commit releases a tag.
- rel_tag, input, TAG_W: released tag.
- ckpt_req, input, 1: snapshot request from a branch being renamed.
- ckpt_gnt, output, 1: snapshot taken.
- ckpt_id, output, clog2(CKPT_DEPTH): id of the snapshot granted this cycle.
- ckpt_free, input, 1: the oldest checkpoint retires (branch resolved correct).
- recover, input, 1: mispredict; restore to checkpoint recover_id.
- recover_id, input, clog2(CKPT_DEPTH): checkpoint to restore.
- free_count, output, TAG_W+1: number of free tags (tail-head).
- ready, output, 1: initialisation complete.
- err, output, 1: sticky protocol error.

Behaviour:
- Reset values: head=tail=0, all checkpoints invalid, state=INIT, ready=0, alloc_gnt=0, ckpt_gnt=0, err=0, free_count=0.
- Pointers are clog2(PHYS_REGS)+1 bits wide. The index is the low bits, so wrap is natural. free_count = tail-head modulo 2^(TAG_W+1).
- FSM INIT:
  - Writes tag ARCH_REGS+i into entry i, one per cycle; tail increments each cycle.
  - After PHYS_REGS-ARCH_REGS cycles, moves to RUN and ready=1. This takes 32 cycles with the defaults.
  - In INIT, alloc/ckpt grants are 0, and recover and ckpt_free are ignored.
  - rel_valid in INIT sets err, and the write is dropped.
- FSM RUN: no other states. An rst_n assertion in any state returns to INIT with all reset values and restarts initialisation from entry 0.
- Allocation:
  - alloc_gnt = alloc_req & RUN & !recover & (free_count!=0). This is combinational; zero latency.
  - alloc_tag = storage[head] combinationally.
  - On grant, head increments at the edge.
  - No bypass of a same-cycle release when empty: gnt=0.
- Release:
  - rel_valid writes rel_tag at tail and increments tail. This is independent of allocate, so simultaneous alloc+release leaves free_count unchanged.
  - Release is accepted even during recover.
  - Release when free_count == PHYS_REGS-ARCH_REGS sets err, and the write is dropped.
- Checkpoints:
  - Circular, in-order, with ckpt_head/ckpt_tail ids and a valid bit per id.
  - ckpt_gnt = ckpt_req & RUN & !recover & (fewer than CKPT_DEPTH valid). ckpt_id = ckpt_tail.
  - The snapshot stores head after this cycle's allocation (head+alloc_gnt), so the branch's own allocation survives recovery.
  - ckpt_free invalidates ckpt_head and advances it. ckpt_free with no valid checkpoint sets err.
- Recovery:
  - On recover with a valid recover_id: at the next edge head <= snapshot[recover_id].
  - recover_id and every younger checkpoint, up to ckpt_tail, are invalidated; ckpt_tail <= recover_id.
  - Same-cycle alloc, ckpt_req and ckpt_free are ignored.
  - recover with an invalid id sets err, and head is unchanged.
- Entries between the snapshot and the current head cannot be overwritten: free plus in-flight tags never exceed PHYS_REGS-ARCH_REGS, which is less than the storage depth.

Test Plan:
- Reset, no requests -> ready rises after 32 cycles with free_count=32; the first alloc grants tag 32, then 33.
- 32 back-to-back allocs -> free_count=0, the 33rd request gives alloc_gnt=0. Release tag 40 -> the next cycle grants tag 40.
- Simultaneous alloc and release of tag 5 for 10 cycles -> free_count constant; tag 5 reappears after the queue wraps.
- ckpt_req with alloc at free_count=30 -> ckpt_id=0, free_count=29. Then 5 allocs, then recover id 0 -> free_count=29, and the next tag is the one first allocated after the checkpoint.
- 4 checkpoints -> 5th ckpt_gnt=0. recover_id=1 -> ids 1..3 invalid, the next ckpt_id=1. Release during recover is still accepted.
- rst_n pulsed at INIT cycle 10 -> restarts and ready after 32 more cycles. Release with a full list, or recover with an invalid id -> err=1 and sticky.
